if_fetch_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_hold_buf.sv | 52 +++++
 rtl/if_fetch_stage.sv | 129 ++++++++++++
 tb/tb_if_fetch_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants.
// Imported by the IF stage and its hold buffer.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST  = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry inst+pc buffer with load/clear/valid.
// Clear wins over load.
module fetch_hold_buf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;

    // Next-state for the entry: clear beats load, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            inst_d  = inst_i;
            pc_d    = pc_i;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, 1-cycle imem requests,
// stall hold buffer and redirect squash into IF_ID.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_en_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o
);

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         req_valid_q, req_valid_d;
    fetch_state_e state_q, state_d;

    logic         hold_valid;
    logic [31:0]  hold_inst;
    logic [31:0]  hold_pc;
    logic         hold_load;
    logic         hold_clr;

    logic [31:0]  tgt_pc;
    logic         live_valid;
    logic [31:0]  live_pc;

    assign tgt_pc     = word_align(redirect_pc_i);
    assign live_valid = req_valid_q && (state_q != ST_BOOT);
    assign live_pc    = req_pc_q + PC_INC;

    // Request issue: a redirect always fetches its target.
    always_comb begin
        imem_en_o   = rst_n && (redirect_i || !stall_i);
        imem_addr_o = redirect_i ? tgt_pc : pc_q;
    end

    // Capture a live response under stall; drop on redirect or release.
    always_comb begin
        hold_load = stall_i && !redirect_i
                    && !hold_valid && live_valid;
        hold_clr  = redirect_i || (!stall_i && hold_valid);
    end

    fetch_hold_buf u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (hold_load),
        .clear_i (hold_clr),
        .inst_i  (imem_rdata_i),
        .pc_i    (live_pc),
        .valid_o (hold_valid),
        .inst_o  (hold_inst),
        .pc_o    (hold_pc)
    );

    // Presented slot: buffer first, then live response, else NOP.
    always_comb begin
        if_valid_o = 1'b0;
        if_inst_o  = NOP_INST;
        if_pc_o    = '0;
        if (rst_n && !redirect_i) begin
            if (hold_valid) begin
                if_valid_o = 1'b1;
                if_inst_o  = hold_inst;
                if_pc_o    = hold_pc;
            end else if (live_valid) begin
                if_valid_o = 1'b1;
                if_inst_o  = imem_rdata_i;
                if_pc_o    = live_pc;
            end
        end
    end

    // Next PC and in-flight request tracking.
    always_comb begin
        pc_d = pc_q + PC_INC;
        if (redirect_i) begin
            pc_d = tgt_pc + PC_INC;
        end else if (stall_i) begin
            pc_d = pc_q;
        end
        req_valid_d = imem_en_o;
        req_pc_d    = imem_addr_o;
    end

    // Fetch state: HOLD while a stalled slot is buffered or pending.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN, ST_HOLD: begin
                if (redirect_i) begin
                    state_d = ST_RUN;
                end else if (stall_i && (hold_valid || live_valid)) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // PC, request and state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
            state_q     <= ST_BOOT;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            state_q     <= state_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage.
// Memory word at byte address a holds (a>>2)+0x100.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_en_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;

    int total;
    int bad;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_en_o     (imem_en_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o),
        .if_valid_o    (if_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory; garbage when no request so stale reuse shows.
    always @(posedge clk) begin
        if (imem_en_o)
            imem_rdata_i <= (imem_addr_o >> 2) + 32'h100;
        else
            imem_rdata_i <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_slot(input string tag,
                            input logic v,
                            input logic [31:0] pc,
                            input logic [31:0] inst);
        chk({tag, ".valid"}, {31'd0, if_valid_o}, {31'd0, v});
        chk({tag, ".pc"}, if_pc_o, pc);
        chk({tag, ".inst"}, if_inst_o, inst);
    endtask

    task automatic chk_req(input string tag,
                           input logic en,
                           input logic [31:0] addr);
        chk({tag, ".en"}, {31'd0, imem_en_o}, {31'd0, en});
        if (en)
            chk({tag, ".addr"}, imem_addr_o, addr);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;

        #3;
        chk_slot("rst", 1'b0, 32'h0, 32'h0);
        chk_req("rst", 1'b0, 32'h0);

        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk_slot("boot", 1'b0, 32'h0, 32'h0);
        chk_req("boot", 1'b1, 32'h0);
        nxt();

        #1 chk_slot("c1", 1'b1, 32'h4, 32'h100);
        nxt();
        #1 chk_slot("c2", 1'b1, 32'h8, 32'h101);
        stall_i = 1'b1;
        #1;
        chk_slot("st0", 1'b1, 32'h8, 32'h101);
        chk_req("st0", 1'b0, 32'h0);
        nxt();
        #1;
        chk_slot("st1", 1'b1, 32'h8, 32'h101);
        chk_req("st1", 1'b0, 32'h0);
        nxt();
        #1;
        chk_slot("st2", 1'b1, 32'h8, 32'h101);
        chk_req("st2", 1'b0, 32'h0);
        nxt();
        stall_i = 1'b0;
        #1;
        chk_slot("rel", 1'b1, 32'h8, 32'h101);
        chk_req("rel", 1'b1, 32'h8);
        nxt();

        #1 chk_slot("c6", 1'b1, 32'hC, 32'h102);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h40;
        #1;
        chk_slot("rd", 1'b0, 32'h0, 32'h0);
        chk_req("rd", 1'b1, 32'h40);
        nxt();
        redirect_i = 1'b0;
        #1 chk_slot("tg0", 1'b1, 32'h44, 32'h110);
        nxt();
        #1 chk_slot("tg1", 1'b1, 32'h48, 32'h111);
        nxt();

        #1 chk_slot("c9", 1'b1, 32'h4C, 32'h112);
        stall_i = 1'b1;
        nxt();
        #1 chk_slot("hfull", 1'b1, 32'h4C, 32'h112);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h80;
        #1;
        chk_slot("rdst", 1'b0, 32'h0, 32'h0);
        chk_req("rdst", 1'b1, 32'h80);
        nxt();
        redirect_i = 1'b0;
        stall_i = 1'b0;
        #1 chk_slot("flush", 1'b1, 32'h84, 32'h120);
        nxt();
        #1 chk_slot("c12", 1'b1, 32'h88, 32'h121);

        redirect_i = 1'b1;
        redirect_pc_i = 32'h4B;
        #1 chk_req("algn", 1'b1, 32'h48);
        nxt();
        redirect_i = 1'b0;
        #1 chk_slot("algn.t", 1'b1, 32'h4C, 32'h112);

        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        #1 chk_req("top", 1'b1, 32'hFFFF_FFFC);
        nxt();
        redirect_i = 1'b0;
        #1;
        chk_req("wrap", 1'b1, 32'h0);
        chk_slot("wrap", 1'b1, 32'h0, 32'h4000_00FF);
        nxt();
        #1 chk_slot("c15", 1'b1, 32'h4, 32'h100);
        stall_i = 1'b1;
        nxt();
        #1 chk_slot("c16", 1'b1, 32'h4, 32'h100);
        rst_n = 1'b0;
        #1;
        chk_slot("arst", 1'b0, 32'h0, 32'h0);
        chk_req("arst", 1'b0, 32'h0);
        nxt();
        stall_i = 1'b0;
        rst_n = 1'b1;
        #1;
        chk_slot("boot2", 1'b0, 32'h0, 32'h0);
        chk_req("boot2", 1'b1, 32'h0);
        nxt();
        #1 chk_slot("r1", 1'b1, 32'h4, 32'h100);
        nxt();
        #1 chk_slot("r2", 1'b1, 32'h8, 32'h101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
